gpio_shift_out: RTL and testbench
=================================

Name: gpio_shift_out

Overview:
- Serial output expander stage directly downstream of the APB GPIO register block.
- Consumes the GPIO output byte and its one-cycle update strobe, and serialises the byte onto a 74HC595-style chain: shift clock, serial data and latch strobe.
- Gives the FPGA board 8+ external outputs over 3 pins.
- One-deep pending buffer absorbs writes that arrive while a transfer is in progress.

Parameters:
- DATA_WIDTH, 8, bits per transfer; width of data_in.
- CLK_DIV, 4, clk cycles per half-period of sr_clk and per latch pulse width; legal range >= 1.
- MSB_FIRST, 1, 1 = data_in[DATA_WIDTH-1] shifted first; 0 = data_in[0] first.

Ports:
- clk  input  1  system clock; all flops on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- data_in  input  DATA_WIDTH  byte to serialise; connects to the GPIO output_port.
- data_valid  input  1  one-cycle strobe, data_in valid; connects to the GPIO output_update.
- sr_clk  output  1  shift clock to external register; data sampled externally on its rising edge.
- sr_data  output  1  serial data.
- sr_latch  output  1  storage-register latch pulse, active high.
- busy  output  1  transfer in progress or pending.
- overrun  output  1  one-cycle pulse: a pending value was overwritten before it was sent.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; shift, pend and counters cleared; pend_valid=0.
  - sr_clk=0, sr_data=0, sr_latch=0, busy=0, overrun=0.
  - Reset mid-transfer aborts immediately with no latch pulse and discards any pending value.
- Outputs: all outputs are flop outputs; no combinational path from inputs to outputs.
- State machine (states IDLE, LOW, HIGH, LATCH; div_cnt counts 0..CLK_DIV-1; bit_cnt counts 0..DATA_WIDTH-1):
  - IDLE, data_valid=1 or pend_valid=1:
    - Load the shift register, from pend if pend_valid=1, else from data_in; clear pend_valid when pend is used.
    - bit_cnt=0, div_cnt=0; go to LOW.
    - On the same edge, sr_data = first bit and sr_clk = 0.
  - LOW: sr_clk=0 and sr_data holds the current bit. When div_cnt=CLK_DIV-1, go to HIGH with sr_clk=1 and div_cnt=0.
  - HIGH: sr_clk=1. When div_cnt=CLK_DIV-1:
    - If bit_cnt=DATA_WIDTH-1: go to LATCH with sr_clk=0, sr_latch=1, sr_data=0.
    - Else: shift, bit_cnt+1, go to LOW with sr_clk=0 and sr_data = next bit.
  - LATCH: sr_latch=1 for CLK_DIV cycles, then IDLE with sr_latch=0.
- Timing per transfer, counted from the accept edge until back in IDLE: 2*CLK_DIV*DATA_WIDTH + CLK_DIV cycles; 68 at the defaults.
  - The first sr_clk rising edge comes CLK_DIV cycles after the accept edge.
  - Back-to-back transfers have exactly 1 IDLE cycle between them.
- sr_data is stable for the full HIGH half-period plus CLK_DIV cycles before the rising edge, which gives setup and hold margin for the external part.
- Pending buffer:
  - data_valid while state != IDLE: pend <= data_in, pend_valid <= 1.
  - If pend_valid was already 1, pend is overwritten (latest value wins) and overrun pulses for 1 cycle.
  - IDLE with pend_valid=1 and data_valid=1 on the same cycle: pend is sent now; data_in is written into pend, pend_valid stays 1, no overrun.
  - IDLE with only data_valid=1: data_in is sent directly.
- busy = (state != IDLE) | pend_valid, registered. It asserts on the edge after data_valid is accepted.
- MSB_FIRST=0 reverses bit order only; timing is identical.

Test Plan:
- Reset then data_valid with data_in=8'hA5 (defaults) -> sr_data bits 1,0,1,0,0,1,0,1 sampled on 8 sr_clk rising edges; the first rising edge is 4 cycles after accept; sr_latch high 4 cycles starting 64 cycles after accept; busy low 68 cycles after accept.
- Write 8'h3C, then 8'hF0 at cycle 10 -> 8'h3C shifted and latched, 1 IDLE cycle, then 8'hF0 shifted and latched; overrun never asserted.
- Writes 8'h01, then 8'h02 at cycle 10, then 8'h03 at cycle 20 -> overrun pulses once at cycle 21; transfers sent are 8'h01 then 8'h03; 8'h02 is never shifted.
- Assert rst for 1 cycle mid-transfer (cycle 30) with a value pending -> all outputs 0 immediately, no latch pulse, pending value discarded; the next write of 8'h55 transfers normally.
- CLK_DIV=1, MSB_FIRST=0, data_in=8'h80 -> sr_clk toggles every cycle; bits 0,0,0,0,0,0,0,1 in that order; transfer takes 17 cycles.
- data_valid in the same IDLE cycle as a pending value -> pending value sent first, new value sent next, no overrun.

Source files
------------

// File: rtl/gpio_shift_out.sv
// Serialises GPIO output bytes onto a 74HC595-style shift-clock / data / latch chain.
// A one-deep pending buffer absorbs writes that arrive while a transfer is running.
module gpio_shift_out #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned CLK_DIV    = 4,
   parameter bit          MSB_FIRST  = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  data_valid,
   output logic                  sr_clk,
   output logic                  sr_data,
   output logic                  sr_latch,
   output logic                  busy,
   output logic                  overrun
);

   localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

   typedef enum logic [1:0] {IDLE, LOW, HIGH, LATCH} state_t;

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [DATA_WIDTH-1:0] pend_q, pend_d;
   logic                  pend_valid_q, pend_valid_d;
   logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
   logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
   logic                  sr_clk_q, sr_clk_d;
   logic                  sr_data_q, sr_data_d;
   logic                  sr_latch_q, sr_latch_d;
   logic                  busy_q, busy_d;
   logic                  overrun_q, overrun_d;

   logic [DATA_WIDTH-1:0] shifted;
   logic [DATA_WIDTH-1:0] load_val;
   logic                  div_done;

   function automatic logic first_bit(input logic [DATA_WIDTH-1:0] v);
      return MSB_FIRST ? v[DATA_WIDTH-1] : v[0];
   endfunction

   assign shifted  = MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);
   assign load_val = pend_valid_q ? pend_q : data_in;
   assign div_done = (div_cnt_q == DIV_LAST);

   // Next-state and next-output logic
   always_comb begin
      state_d      = state_q;
      shift_d      = shift_q;
      pend_d       = pend_q;
      pend_valid_d = pend_valid_q;
      div_cnt_d    = div_cnt_q + DIV_W'(1);
      bit_cnt_d    = bit_cnt_q;
      sr_clk_d     = sr_clk_q;
      sr_data_d    = sr_data_q;
      sr_latch_d   = sr_latch_q;
      overrun_d    = 1'b0;

      case (state_q)
         IDLE: begin
            div_cnt_d = '0;
            if (pend_valid_q || data_valid) begin
               shift_d   = load_val;
               bit_cnt_d = '0;
               sr_data_d = first_bit(load_val);
               sr_clk_d  = 1'b0;
               state_d   = LOW;
            end
            // Pending value goes out now; a same-cycle write refills the buffer
            if (pend_valid_q) begin
               pend_valid_d = data_valid;
               if (data_valid) begin
                  pend_d = data_in;
               end
            end
         end
         LOW: begin
            if (div_done) begin
               div_cnt_d = '0;
               sr_clk_d  = 1'b1;
               state_d   = HIGH;
            end
         end
         HIGH: begin
            if (div_done) begin
               div_cnt_d = '0;
               sr_clk_d  = 1'b0;
               if (bit_cnt_q == BIT_LAST) begin
                  sr_latch_d = 1'b1;
                  sr_data_d  = 1'b0;
                  state_d    = LATCH;
               end else begin
                  shift_d   = shifted;
                  bit_cnt_d = bit_cnt_q + BIT_W'(1);
                  sr_data_d = first_bit(shifted);
                  state_d   = LOW;
               end
            end
         end
         LATCH: begin
            if (div_done) begin
               div_cnt_d  = '0;
               sr_latch_d = 1'b0;
               state_d    = IDLE;
            end
         end
         default: begin
            div_cnt_d = '0;
            state_d   = IDLE;
         end
      endcase

      if ((state_q != IDLE) && data_valid) begin
         pend_d       = data_in;
         pend_valid_d = 1'b1;
         overrun_d    = pend_valid_q;
      end

      busy_d = (state_d != IDLE) | pend_valid_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         shift_q      <= '0;
         pend_q       <= '0;
         pend_valid_q <= 1'b0;
         div_cnt_q    <= '0;
         bit_cnt_q    <= '0;
         sr_clk_q     <= 1'b0;
         sr_data_q    <= 1'b0;
         sr_latch_q   <= 1'b0;
         busy_q       <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         shift_q      <= shift_d;
         pend_q       <= pend_d;
         pend_valid_q <= pend_valid_d;
         div_cnt_q    <= div_cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         sr_clk_q     <= sr_clk_d;
         sr_data_q    <= sr_data_d;
         sr_latch_q   <= sr_latch_d;
         busy_q       <= busy_d;
         overrun_q    <= overrun_d;
      end
   end

   assign sr_clk   = sr_clk_q;
   assign sr_data  = sr_data_q;
   assign sr_latch = sr_latch_q;
   assign busy     = busy_q;
   assign overrun  = overrun_q;

endmodule

// File: tb/tb_gpio_shift_out.sv
// Scoreboard bench for gpio_shift_out: lane 0 uses the defaults, lane 1 uses
// CLK_DIV=1 with LSB-first order. A transaction-level model predicts each latched byte.
module tb_gpio_shift_out;

   localparam int unsigned DW = 8;

   typedef struct {
      logic [DW-1:0] data;
      int            acc;
   } xfer_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [1:0]    dv_w;
   logic [DW-1:0] din_w [2];
   logic [1:0]    sclk_w, sdat_w, slat_w, busy_w, ovr_w;

   int n_checks = 0;
   int n_errors = 0;
   bit finishing = 1'b0;

   always #5 clk = ~clk;

   function automatic void check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endfunction

   for (genvar g = 0; g < 2; g++) begin : lane
      localparam int unsigned CD   = (g == 0) ? 4 : 1;
      localparam bit          MSBF = (g == 0);
      localparam int          T    = int'(2 * CD * DW + CD);

      gpio_shift_out #(.DATA_WIDTH(DW), .CLK_DIV(CD), .MSB_FIRST(MSBF)) dut (
         .clk       (clk),
         .rst       (rst),
         .data_in   (din_w[g]),
         .data_valid(dv_w[g]),
         .sr_clk    (sclk_w[g]),
         .sr_data   (sdat_w[g]),
         .sr_latch  (slat_w[g]),
         .busy      (busy_w[g]),
         .overrun   (ovr_w[g])
      );

      xfer_t         exp_q[$];
      int            ovr_q[$];
      xfer_t         nx;
      xfer_t         e;
      int            cyc      = 0;
      int            free_at  = 0;
      bit            pend_v   = 1'b0;
      logic [DW-1:0] pend     = '0;
      bit            exp_busy = 1'b0;

      // Transaction model: a transfer occupies T cycles, then one idle cycle
      initial forever begin
         @(posedge clk);
         cyc++;
         if (rst) begin
            pend_v  = 1'b0;
            free_at = 0;
            exp_q.delete();
            ovr_q.delete();
         end else if (cyc >= free_at) begin
            if (pend_v) begin
               nx.data = pend;
               nx.acc  = cyc;
               exp_q.push_back(nx);
               free_at = cyc + T + 1;
               if (dv_w[g]) pend = din_w[g];
               else         pend_v = 1'b0;
            end else if (dv_w[g]) begin
               nx.data = din_w[g];
               nx.acc  = cyc;
               exp_q.push_back(nx);
               free_at = cyc + T + 1;
            end
         end else if (dv_w[g]) begin
            if (pend_v) ovr_q.push_back(cyc);
            pend   = din_w[g];
            pend_v = 1'b1;
         end
         exp_busy = (cyc < free_at - 1) || pend_v;
      end

      bit            pclk       = 1'b0;
      bit            plat       = 1'b0;
      int            nbits      = 0;
      int            first_rise = 0;
      int            lat_rise   = 0;
      logic [DW-1:0] acc        = '0;
      bit            end_done   = 1'b0;
      int            ov_cyc;

      // Monitor: rebuild each shifted word and compare at the latch pulse
      initial forever begin
         @(negedge clk);
         if (rst) begin
            check($sformatf("lane%0d reset outputs", g),
                  int'({sclk_w[g], sdat_w[g], slat_w[g], busy_w[g], ovr_w[g]}), 0);
            pclk  = 1'b0;
            plat  = 1'b0;
            nbits = 0;
         end else begin
            if (sclk_w[g] && !pclk) begin
               if (nbits == 0) first_rise = cyc;
               acc = MSBF ? {acc[DW-2:0], sdat_w[g]} : {sdat_w[g], acc[DW-1:1]};
               nbits++;
            end
            if (slat_w[g] && !plat) begin
               lat_rise = cyc;
               check($sformatf("lane%0d latch has queued transfer", g), int'(exp_q.size() > 0), 1);
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  check($sformatf("lane%0d latched data", g), int'(acc), int'(e.data));
                  check($sformatf("lane%0d bits per transfer", g), nbits, int'(DW));
                  check($sformatf("lane%0d first sr_clk rise delay", g), first_rise - e.acc, int'(CD));
                  check($sformatf("lane%0d latch start delay", g), lat_rise - e.acc, int'(2 * CD * DW));
               end
               nbits = 0;
            end
            if (!slat_w[g] && plat)
               check($sformatf("lane%0d latch width", g), cyc - lat_rise, int'(CD));
            if (ovr_w[g]) begin
               check($sformatf("lane%0d overrun expected", g), int'(ovr_q.size() > 0), 1);
               if (ovr_q.size() > 0) begin
                  ov_cyc = ovr_q.pop_front();
                  check($sformatf("lane%0d overrun cycle", g), cyc, ov_cyc);
               end
            end
            check($sformatf("lane%0d busy", g), int'(busy_w[g]), int'(exp_busy));
            pclk = sclk_w[g];
            plat = slat_w[g];
         end
         if (finishing && !end_done) begin
            end_done = 1'b1;
            check($sformatf("lane%0d transfers left unsent", g), exp_q.size(), 0);
            check($sformatf("lane%0d overruns not seen", g), ovr_q.size(), 0);
         end
      end
   end

   task automatic step(input logic v0, input logic [DW-1:0] d0,
                       input logic v1, input logic [DW-1:0] d1);
      @(negedge clk);
      #2;
      dv_w[0]  = v0;
      din_w[0] = d0;
      dv_w[1]  = v1;
      din_w[1] = d1;
   endtask

   task automatic wr0(input logic [DW-1:0] d);
      step(1'b1, d, 1'b0, '0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0);
   endtask

   initial begin
      rst      = 1'b1;
      dv_w     = '0;
      din_w[0] = '0;
      din_w[1] = '0;
      repeat (3) @(negedge clk);
      #2 rst = 1'b0;

      // Single transfer on each lane
      step(1'b1, 8'hA5, 1'b1, 8'h80);
      idle(79);

      // Second write lands in the pending buffer
      wr0(8'h3C); idle(9); wr0(8'hF0); idle(150);

      // Overwritten pending value raises overrun once
      wr0(8'h01); idle(9); wr0(8'h02); idle(9); wr0(8'h03); idle(150);

      // Write coinciding with the idle cycle that sends the pending value
      wr0(8'h11); idle(9); wr0(8'h22); idle(58); wr0(8'h33); idle(150);

      // Reset mid-transfer with a value pending
      wr0(8'h44); idle(9); wr0(8'h66); idle(19);
      @(negedge clk);
      #2 rst = 1'b1;
      #1 check("async reset clears outputs",
               int'({sclk_w[0], sdat_w[0], slat_w[0], busy_w[0], ovr_w[0]}), 0);
      @(negedge clk);
      #2 rst = 1'b0;
      wr0(8'h55); idle(80);

      // Random traffic on both lanes
      for (int i = 0; i < 1500; i++)
         step(($urandom_range(0, 24) == 0), 8'($urandom),
              ($urandom_range(0, 8) == 0), 8'($urandom));
      idle(200);

      finishing = 1'b1;
      idle(3);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
